// File: rtl/inst_queue_pkg.sv
// Shared front-end sizing constants used by fetch, the instruction queue and decode.
// Optional almost-full output is enabled with the IQ_ALMOST_FULL_EN macro.
package inst_queue_pkg;

    localparam int unsigned InstSize = 32;
    localparam logic [InstSize-1:0] zero = '0;
    localparam logic [InstSize-1:0] one  = {{(InstSize-1){1'b0}}, 1'b1};

    // Fetch and decode both size their bookkeeping from these.
    localparam int unsigned IQ_DEPTH_LOG = 4;
    localparam int unsigned IQ_DEPTH     = 1 << IQ_DEPTH_LOG;

    typedef struct packed {
        logic [InstSize-1:0] inst;
        logic [InstSize-1:0] pc;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch/decode handshake bundle of the instruction queue; master = fetch+decode, slave = queue.
// almost_full exists only when IQ_ALMOST_FULL_EN is defined.
interface inst_queue_if #(
    parameter int unsigned INST_W = inst_queue_pkg::InstSize
);

    logic              fetch_en;
    logic [INST_W-1:0] fetch_inst;
    logic [INST_W-1:0] fetch_pc;
    logic              IQ_isfull;
`ifdef IQ_ALMOST_FULL_EN
    logic              almost_full;
`endif
    logic              Get_Inst;
    logic              en_out;
    logic [INST_W-1:0] Inst_out;
    logic [INST_W-1:0] pc_out;
    logic              IQ_isempty;

    modport master (
        output fetch_en, fetch_inst, fetch_pc, Get_Inst,
`ifdef IQ_ALMOST_FULL_EN
        input  almost_full,
`endif
        input  IQ_isfull, en_out, Inst_out, pc_out, IQ_isempty
    );

    modport slave (
        input  fetch_en, fetch_inst, fetch_pc, Get_Inst,
`ifdef IQ_ALMOST_FULL_EN
        output almost_full,
`endif
        output IQ_isfull, en_out, Inst_out, pc_out, IQ_isempty
    );

endinterface

// File: rtl/iq_ram.sv
// Entry storage for the instruction queue: one synchronous write port and one
// registered read port whose output register resets to zero and holds when not read.
module iq_ram #(
    parameter int unsigned DEPTH_LOG = 4,
    parameter int unsigned WIDTH     = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [DEPTH_LOG-1:0] waddr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 re_i,
    input  logic [DEPTH_LOG-1:0] raddr_i,
    output logic [WIDTH-1:0]     rdata_o
);

    localparam int unsigned Depth = 1 << DEPTH_LOG;

    logic [WIDTH-1:0] mem_q [Depth];
    logic [WIDTH-1:0] rdata_q, rdata_d;

    // Entry contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[raddr_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode with a registered one-cycle pop.
// Defining IQ_ALMOST_FULL_EN adds the almost_full output (free slots <= AFULL_MARGIN).
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH_LOG    = IQ_DEPTH_LOG,
    parameter int unsigned INST_W       = InstSize
`ifdef IQ_ALMOST_FULL_EN
    ,
    parameter int unsigned AFULL_MARGIN = 2
`endif
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         rdy_in,
    input  logic         clear,
    inst_queue_if.slave  bus
);

    localparam int unsigned Depth = 1 << DEPTH_LOG;
    localparam int unsigned CntW  = DEPTH_LOG + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [DEPTH_LOG-1:0] head_q, head_d;
    logic [DEPTH_LOG-1:0] tail_q, tail_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 en_out_q, en_out_d;

    logic                 full, empty;
    logic                 push_ok, pop_ok;
    logic                 advance;
    logic [2*INST_W-1:0]  rd_data;

    assign full    = (count_q == DepthCnt);
    assign empty   = (count_q == '0);
    assign push_ok = bus.fetch_en && !full;
    assign pop_ok  = bus.Get_Inst && !empty;
    // Storage may only move on edges that actually commit the handshake.
    assign advance = rdy_in && !clear;

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        en_out_d = en_out_q;
        if (clear) begin
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            en_out_d = 1'b0;
        end else if (rdy_in) begin
            if (push_ok) begin
                tail_d = tail_q + 1'b1;
            end
            if (pop_ok) begin
                head_d = head_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - 1'b1;
            end
            en_out_d = pop_ok;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            en_out_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            en_out_q <= en_out_d;
        end
    end

    iq_ram #(
        .DEPTH_LOG (DEPTH_LOG),
        .WIDTH     (2 * INST_W)
    ) u_iq_ram (
        .clk_i   (clk_in),
        .rst_ni  (rst_n_in),
        .we_i    (advance && push_ok),
        .waddr_i (tail_q),
        .wdata_i ({bus.fetch_inst, bus.fetch_pc}),
        .re_i    (advance && pop_ok),
        .raddr_i (head_q),
        .rdata_o (rd_data)
    );

    assign bus.Inst_out   = rd_data[2*INST_W-1:INST_W];
    assign bus.pc_out     = rd_data[INST_W-1:0];
    assign bus.en_out     = en_out_q;
    assign bus.IQ_isfull  = full;
    assign bus.IQ_isempty = empty;

`ifdef IQ_ALMOST_FULL_EN
    assign bus.almost_full = (DepthCnt - count_q) <= CntW'(AFULL_MARGIN);
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue; checks almost_full too when
// IQ_ALMOST_FULL_EN is defined.
module tb_inst_queue;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    logic rdy_in   = 1'b1;
    logic clear    = 1'b0;

    int tests = 0;
    int fails = 0;

    inst_queue_if #(.INST_W(32)) bus ();

    inst_queue #(
        .DEPTH_LOG (4),
        .INST_W    (32)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rdy_in   (rdy_in),
        .clear    (clear),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_set(input logic en, input logic [31:0] pc);
        bus.fetch_en   = en;
        bus.fetch_pc   = pc;
        bus.fetch_inst = inst_of(pc);
    endtask

    task automatic check_pop(input string tag, input logic [31:0] pc);
        check({tag, "_en"}, 32'(bus.en_out), 32'd1);
        check({tag, "_pc"}, bus.pc_out, pc);
        check({tag, "_inst"}, bus.Inst_out, inst_of(pc));
    endtask

    initial begin
        push_set(1'b0, 32'h0);
        bus.Get_Inst = 1'b0;
        tick();
        tick();
        check("rst_en_out", 32'(bus.en_out), 32'd0);
        check("rst_inst_out", bus.Inst_out, 32'h0);
        check("rst_pc_out", bus.pc_out, 32'h0);
        check("rst_empty", 32'(bus.IQ_isempty), 32'd1);
        check("rst_full", 32'(bus.IQ_isfull), 32'd0);
`ifdef IQ_ALMOST_FULL_EN
        check("rst_afull", 32'(bus.almost_full), 32'd0);
`endif
        rst_n_in = 1'b1;
        tick();

        // Three pushes, then three back-to-back pops.
        for (int i = 0; i < 3; i++) begin
            push_set(1'b1, 32'(4 * i));
            tick();
        end
        push_set(1'b0, 32'h0);
        bus.Get_Inst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_pop("t1_pop", 32'(4 * i));
        end
        bus.Get_Inst = 1'b0;
        tick();
        check("t1_en_low", 32'(bus.en_out), 32'd0);
        check("t1_empty", 32'(bus.IQ_isempty), 32'd1);

        // Fill to 16, then push-while-full cases.
        for (int i = 0; i < 16; i++) begin
            push_set(1'b1, 32'(4 * i));
            tick();
            check("t2_full", 32'(bus.IQ_isfull), 32'(i == 15));
`ifdef IQ_ALMOST_FULL_EN
            check("t2_afull", 32'(bus.almost_full), 32'(i + 1 >= 14));
`endif
        end
        push_set(1'b1, 32'h40);
        tick();
        check("t2_drop_full", 32'(bus.IQ_isfull), 32'd1);
        check("t2_drop_en", 32'(bus.en_out), 32'd0);
        bus.Get_Inst = 1'b1;
        tick();
        check_pop("t2_pop_only", 32'h0);
        check("t2_pop_only_full", 32'(bus.IQ_isfull), 32'd0);
        bus.Get_Inst = 1'b0;
        tick();
        check("t2_retry_full", 32'(bus.IQ_isfull), 32'd1);
        check("t2_retry_en", 32'(bus.en_out), 32'd0);
        push_set(1'b0, 32'h0);
        bus.Get_Inst = 1'b1;
        for (int j = 0; j < 16; j++) begin
            tick();
            check_pop("t2_drain", 32'(4 * (j + 1)));
        end
        bus.Get_Inst = 1'b0;
        tick();
        check("t2_empty", 32'(bus.IQ_isempty), 32'd1);

        // Pop from empty, then push+pop together from empty.
        bus.Get_Inst = 1'b1;
        tick();
        check("t3_empty_pop_en", 32'(bus.en_out), 32'd0);
        check("t3_hold_pc", bus.pc_out, 32'h40);
        check("t3_hold_inst", bus.Inst_out, inst_of(32'h40));
        push_set(1'b1, 32'h100);
        tick();
        check("t3_nobypass_en", 32'(bus.en_out), 32'd0);
        check("t3_notempty", 32'(bus.IQ_isempty), 32'd0);
        push_set(1'b0, 32'h0);
        tick();
        check_pop("t3_pop", 32'h100);
        bus.Get_Inst = 1'b0;
        tick();
        check("t3_en_low", 32'(bus.en_out), 32'd0);
        check("t3_empty", 32'(bus.IQ_isempty), 32'd1);

        // Pop at count 5 followed by three rdy-low cycles with live requests.
        for (int i = 0; i < 5; i++) begin
            push_set(1'b1, 32'h200 + 32'(4 * i));
            tick();
        end
        push_set(1'b0, 32'h0);
        bus.Get_Inst = 1'b1;
        tick();
        check_pop("t4_pop", 32'h200);
        rdy_in = 1'b0;
        push_set(1'b1, 32'hBAD0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_pop("t4_frozen", 32'h200);
        end
        rdy_in = 1'b1;
        push_set(1'b0, 32'h0);
        bus.Get_Inst = 1'b0;
        tick();
        check("t4_en_consumed", 32'(bus.en_out), 32'd0);
        check("t4_pc_hold", bus.pc_out, 32'h200);
        bus.Get_Inst = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            check_pop("t4_drain", 32'h204 + 32'(4 * j));
        end
        bus.Get_Inst = 1'b0;
        tick();
        check("t4_empty", 32'(bus.IQ_isempty), 32'd1);

        // Clear at count 7 with simultaneous push and pop.
        for (int i = 0; i < 7; i++) begin
            push_set(1'b1, 32'h300 + 32'(4 * i));
            tick();
        end
        check("t5_notempty", 32'(bus.IQ_isempty), 32'd0);
        clear = 1'b1;
        push_set(1'b1, 32'h400);
        bus.Get_Inst = 1'b1;
        tick();
        check("t5_clear_en", 32'(bus.en_out), 32'd0);
        check("t5_clear_empty", 32'(bus.IQ_isempty), 32'd1);
        clear = 1'b0;
        push_set(1'b1, 32'h500);
        bus.Get_Inst = 1'b0;
        tick();
        check("t5_push_notempty", 32'(bus.IQ_isempty), 32'd0);
        push_set(1'b0, 32'h0);
        bus.Get_Inst = 1'b1;
        tick();
        check_pop("t5_pop", 32'h500);
        bus.Get_Inst = 1'b0;
        tick();
        check("t5_empty", 32'(bus.IQ_isempty), 32'd1);

        // Stream 40 entries through; pointers wrap more than twice.
        for (int k = 0; k <= 40; k++) begin
            push_set(k < 40, 32'h1000 + 32'(4 * k));
            bus.Get_Inst = (k >= 1);
            tick();
            if (k >= 1) begin
                check("t6_en", 32'(bus.en_out), 32'd1);
                check("t6_pc", bus.pc_out, 32'h1000 + 32'(4 * (k - 1)));
            end
        end
        push_set(1'b0, 32'h0);
        bus.Get_Inst = 1'b0;
        tick();
        check("t6_en_low", 32'(bus.en_out), 32'd0);
        check("t6_empty", 32'(bus.IQ_isempty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Instruction queue between the fetch unit (writer) and the decode stage (reader).
- Stores fetched {instruction, pc} pairs in a circular FIFO.
- Serves the decoder through a registered one-cycle pop handshake: decoder raises Get_Inst, queue answers with en_out plus data.
- Flushed by the pipeline-wide clear on branch mispredict.

Parameters:
- DEPTH_LOG, 4, log2 of entry count (16 entries)
- INST_W, 32, width of instruction word and of pc
- AFULL_MARGIN, 2, free-slot threshold for almost_full (optional feature only)

Ports:
- clk_in  input  1  clock, rising edge
- rst_n_in  input  1  asynchronous reset, active low
- rdy_in  input  1  global ready; low freezes the block
- clear  input  1  synchronous flush (mispredict)
- fetch_en  input  1  push request from fetch unit
- fetch_inst  input  INST_W  instruction to push
- fetch_pc  input  INST_W  pc of the pushed instruction
- IQ_isfull  output  1  count == 2^DEPTH_LOG
- Get_Inst  input  1  pop request from decoder
- en_out  output  1  Inst_out/pc_out valid for exactly one rdy-high edge
- Inst_out  output  INST_W  popped instruction
- pc_out  output  INST_W  popped pc
- IQ_isempty  output  1  count == 0

Behaviour:
- State: head ptr, tail ptr (DEPTH_LOG bits, wrap naturally), count (DEPTH_LOG+1 bits), entry array.
- IQ_isfull and IQ_isempty are combinational from registered count.
- Reset (async, rst_n_in=0): head=tail=count=0; en_out=0; Inst_out=0; pc_out=0. Entry contents are don't-care.
- Priority per edge: reset > clear > rdy_in low > normal.
- clear=1 (regardless of rdy_in): head=tail=count=0, en_out=0. Pushes and pops that cycle are discarded.
- rdy_in=0: all state and outputs hold, including en_out. The decoder likewise ignores that edge, so a pending en_out is consumed on the first rdy-high edge.
- Normal cycle, evaluated on pre-edge count:
  - push_ok = fetch_en && count < DEPTH. Writes {fetch_inst, fetch_pc} at tail; tail+1.
  - pop_ok = Get_Inst && count > 0. Registers entry[head] onto Inst_out/pc_out, sets en_out=1, head+1.
  - If Get_Inst && count == 0: en_out=0, data outputs hold. Get_Inst is registered in the decoder and may be stale, so this is legal.
  - If not pop_ok: en_out=0.
  - count += push_ok - pop_ok.
  - Push and pop in the same cycle with count == DEPTH: pop only; the fetcher retries.
  - Push and pop in the same cycle with count == 0: push only; no bypass, the entry is readable from the next edge.
- Pop latency: Get_Inst sampled at edge N gives data valid after edge N; the decoder samples it at edge N+1.
- Push while full: dropped silently. The fetcher must hold fetch_en/data until IQ_isfull is low.
- Pointer wrap: tail/head DEPTH-1 -> 0, no bubble.

Optional Feature:
- Macro IQ_ALMOST_FULL_EN.
- Defined: extra output port almost_full (1 bit) = (DEPTH - count) <= AFULL_MARGIN, combinational. The fetcher uses it to stop issuing memory requests early.
- Undefined: port and logic absent; AFULL_MARGIN unused.

Decomposition:
- Shared defines header (existing): InstSize, zero, one.
- Add IQ_DEPTH_LOG and IQ_DEPTH constants there so fetch and decode agree on sizing.
- One natural sub-module: iq_ram, a 1-write/1-read synchronous array with write at tail and registered read at head.
- Pointers, count and handshake logic stay in inst_queue.

Test Plan:
- Reset, then push 3 (pc 0x0,0x4,0x8), Get_Inst held 3 cycles -> en_out high 3 consecutive cycles with pc_out 0x0,0x4,0x8; IQ_isempty=1 afterwards.
- Fill 16 entries -> IQ_isfull=1. Push 17th (pc 0x40) with Get_Inst low -> dropped, count stays 16. Push again with Get_Inst high -> pop only, count 15. Next cycle push accepted -> count 16.
- Get_Inst with queue empty -> en_out=0, Inst_out unchanged. Push and Get_Inst in the same cycle from empty -> en_out=0 that cycle, en_out=1 next cycle with the pushed pc.
- Pop at count=5 with rdy_in dropped for 3 cycles after the pop edge -> en_out and data held 3 cycles, then en_out=0 after the first rdy-high edge; count=4 throughout.
- clear asserted at count=7 with simultaneous push and Get_Inst -> count=0, en_out=0, IQ_isempty=1 next cycle; the next push lands and pops correctly.
- Push/pop 40 entries streaming through a 16-entry queue -> correct order across pointer wrap. With IQ_ALMOST_FULL_EN: almost_full rises at count 14.
